mld_15_7_encoder: RTL and testbench
===================================

// Module: mld_15_7_encoder
// PURPOSE
//  Bit-serial systematic encoder for the (15,7) cyclic majority-logic-decodable code. It is the
//  transmit end paired with the (15,7) majority logic decoder.
//  Accepts 7 message bits, emits the 15-bit codeword highest-degree bit first: m6..m0, then p7..p0.
//  Parity is the remainder of x^8*m(x) mod g(x), with g(x)=x^8+x^7+x^6+x^4+1.
//  A registered output stage with valid/ready handshakes on both sides sits between the LFSR and the link.
// PARAMETERS
//  N         15        codeword length (bits per frame)
//  K         7         message length; N-K = 8 parity bits
//  GEN_POLY  9'h1D1    generator coeffs g8..g0 (g8=g0=1 implied); width N-K+1
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-low reset
//  clear        in   1  synchronous abort: drop partial frame, return to message phase
//  in_valid     in   1  in_bit holds a message bit
//  in_ready     out  1  encoder accepts a message bit this cycle
//  in_bit       in   1  message bit, m6 first
//  out_valid    out  1  out_bit holds a codeword bit
//  out_ready    in   1  sink accepts out_bit this cycle
//  out_bit      out  1  codeword bit, c14 first
//  out_first    out  1  qualifies out_bit as c14 (frame start)
//  out_last     out  1  qualifies out_bit as c0 (frame end)
//  busy         out  1  a frame is partially accepted or emitted (bit_cnt!=0 or out_valid)
// BEHAVIOUR
//  Reset (reset==0, async): out_valid=0, out_bit=0, out_first=0, out_last=0, busy=0.
//   Also: LFSR p[7:0]=0, bit_cnt=0, phase=MSG. in_ready follows the rules below (=1 after reset).
//  can_load = !out_valid || out_ready. An output transfer is out_valid && out_ready.
//  Output register holds out_bit/out_first/out_last stable while out_valid && !out_ready.
//  Phase MSG (bit_cnt 0..6): in_ready = can_load.
//   On in_valid && in_ready: out_bit<=in_bit, out_valid<=1, out_first<=(bit_cnt==0), bit_cnt++.
//   On the same beat, the LFSR updates with f = in_bit ^ p[7]: p[0]<=f, and for i=1..7
//   p[i]<=p[i-1]^(GEN_POLY[i]&f). With the default, taps are at p4, p6, p7.
//   After the beat that accepts m0 (bit_cnt 6->7), phase<=PAR.
//  Phase PAR (bit_cnt 7..14): in_ready=0. When can_load:
//   out_bit<=p[7], out_valid<=1, p<={p[6:0],1'b0}, bit_cnt++.
//   out_last<=(bit_cnt==14). bit_cnt 14 -> 0 and phase<=MSG. The LFSR is then zero by construction.
//  No load in a cycle with can_load: out_valid<=0 once the pending bit transfers.
//  Latency: codeword bit appears on out_bit the cycle after its message bit is accepted.
//  Throughput: 15 cycles per frame when out_ready=1 and in_valid=1 back-to-back.
//   Frame n+1 m6 may be accepted in the cycle after c0 is loaded; there are no bubbles.
//  The source may stall (in_valid=0) mid-message: the LFSR and bit_cnt hold. Parity emission
//   never waits on in_valid.
//  The sink may stall any time: nothing advances while out_valid && !out_ready.
//  clear (sync, beats all other activity that cycle):
//   bit_cnt<=0, p<=0, phase<=MSG, out_valid<=0, out_first<=0, out_last<=0.
//   A pending out_bit is discarded.
//  Async reset mid-frame: immediate return to reset state. No partial codeword resumes.
//  bit_cnt is 4 bits and never exceeds N-1. in_valid while in_ready=0 is ignored; the bit is not consumed.
// TESTING
//  1) Message 0000001 (m6..m0), out_ready=1 -> 15 bits 0000001_11010001. This is g(x).
//     out_first with bit 1, out_last with bit 15.
//  2) Message 1000000 -> 1000000_11101000. Message 1111111 -> 15 ones. Message 0000000 -> 15 zeros.
//  3) Back-to-back frames 0000001 then 1000000 -> 30 contiguous out_valid cycles, no bubble,
//     and the second frame is correct (LFSR clean).
//  4) out_ready low 3 cycles during parity bit p5 -> out_bit/out_last stable, in_ready=0.
//     Frame is correct after release.
//  5) clear after 4 message bits, then message 0000001 -> out_valid=0 the cycle after clear,
//     then the clean codeword from test 1.
//  6) reset asserted mid-parity -> all outputs 0 immediately. Next frame encodes correctly.
//     Also feed received streams to the (15,7) decoder: error-free stream decodes to the message.

Source files
------------

// File: rtl/mld_15_7_encoder.sv
// Bit-serial systematic (15,7) cyclic encoder: message bits pass straight through, then the
// LFSR remainder x^(N-K)*m(x) mod g(x) is shifted out, all behind one registered output stage.
module mld_15_7_encoder #(
    parameter int             N        = 15,
    parameter int             K        = 7,
    parameter logic [N-K:0]   GEN_POLY = 9'h1D1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_first,
    output logic out_last,
    output logic busy
);

    localparam int P  = N - K;
    localparam int CW = $clog2(N);

    typedef enum logic {MSG, PAR} phase_t;

    phase_t          phase, phase_nxt;
    logic [CW-1:0]   bit_cnt, cnt_nxt;
    logic [P-1:0]    par, par_nxt;
    logic            ov_nxt, ob_nxt, of_nxt, ol_nxt;
    logic            can_load, fb;

    assign can_load = !out_valid || out_ready;
    assign in_ready = (phase == MSG) && can_load;
    assign busy     = (bit_cnt != '0) || out_valid;
    assign fb       = in_bit ^ par[P-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= MSG;
            bit_cnt   <= '0;
            par       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            bit_cnt   <= cnt_nxt;
            par       <= par_nxt;
            out_valid <= ov_nxt;
            out_bit   <= ob_nxt;
            out_first <= of_nxt;
            out_last  <= ol_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = bit_cnt;
        par_nxt   = par;
        ov_nxt    = out_valid;
        ob_nxt    = out_bit;
        of_nxt    = out_first;
        ol_nxt    = out_last;
        if (clear) begin
            // abort wins over any load; a pending output bit is dropped
            phase_nxt = MSG;
            cnt_nxt   = '0;
            par_nxt   = '0;
            ov_nxt    = 1'b0;
            of_nxt    = 1'b0;
            ol_nxt    = 1'b0;
        end else if (can_load) begin
            if (phase == PAR) begin
                // parity emission never waits on the source
                ob_nxt  = par[P-1];
                ov_nxt  = 1'b1;
                of_nxt  = 1'b0;
                ol_nxt  = (bit_cnt == CW'(N-1));
                par_nxt = {par[P-2:0], 1'b0};
                if (bit_cnt == CW'(N-1)) begin
                    cnt_nxt   = '0;
                    phase_nxt = MSG;
                end else begin
                    cnt_nxt = bit_cnt + CW'(1);
                end
            end else if (in_valid) begin
                ob_nxt     = in_bit;
                ov_nxt     = 1'b1;
                of_nxt     = (bit_cnt == '0);
                ol_nxt     = 1'b0;
                par_nxt[0] = fb;
                for (int i = 1; i < P; i++)
                    par_nxt[i] = par[i-1] ^ (GEN_POLY[i] & fb);
                cnt_nxt = bit_cnt + CW'(1);
                if (bit_cnt == CW'(K-1))
                    phase_nxt = PAR;
            end else begin
                ov_nxt = 1'b0;
                of_nxt = 1'b0;
                ol_nxt = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mld_15_7_encoder.sv
// Scoreboarded bench for mld_15_7_encoder: expected codeword bits are queued as frames are
// driven and popped whenever the encoder hands a bit to the sink.
module tb_mld_15_7_encoder;

    logic clk = 1'b0;
    logic reset, clear, in_valid, in_ready, in_bit;
    logic out_valid, out_ready, out_bit, out_first, out_last, busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];   // {bit, first, last}

    localparam logic [14:0] CW_G    = 15'b0000001_11010001;
    localparam logic [14:0] CW_X6   = 15'b1000000_11101000;
    localparam logic [14:0] CW_ONES = 15'h7FFF;
    localparam logic [14:0] CW_ZERO = 15'h0000;

    mld_15_7_encoder dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // long division of x^8*m(x) by g(x)
    function automatic logic [14:0] encode(input logic [6:0] msg);
        logic [14:0] r;
        logic [8:0]  g;
        g = 9'h1D1;
        r = {msg, 8'b0};
        for (int i = 14; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ g;
        return {msg, r[7:0]};
    endfunction

    task automatic push_frame(input logic [14:0] cw);
        for (int i = 14; i >= 0; i--)
            exp_q.push_back({cw[i], i == 14, i == 0});
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            logic [2:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got bit/first/last %b%b%b, required none", out_bit, out_first, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_bit, out_first, out_last} !== e) begin
                    n_err++;
                    $display("FAIL out_bit: got bit/first/last %b%b%b, required %b", out_bit, out_first, out_last, e);
                end
            end
        end
    end

    task automatic drive(input logic [6:0] msg, input int nbits, input bit hold);
        for (int i = 6; i > 6 - nbits; i--) begin
            bit acc;
            int to;
            in_valid = 1'b1;
            in_bit   = msg[i];
            acc = 0;
            to  = 0;
            while (!acc && to < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                to++;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL drive_timeout: in_ready never 1 for bit %0d", i);
            end
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_bit, out_first, out_last, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v/b/f/l/busy %b%b%b%b%b, required 00000",
                     out_valid, out_bit, out_first, out_last, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_patterns();
        logic [14:0] cws[4];
        cws = '{CW_G, CW_X6, CW_ONES, CW_ZERO};
        for (int f = 0; f < 4; f++) begin
            push_frame(cws[f]);
            drive(cws[f][14:8], 7, 1'b0);
            wait_drain();
            n_cmp++;
            if (exp_q.size() !== 0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL pattern_%0d_drain: got left=%0d busy=%b, required 0 0", f, exp_q.size(), busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int run;
        run = 0;
        push_frame(CW_G);
        push_frame(CW_X6);
        fork
            begin
                drive(7'b0000001, 7, 1'b1);
                drive(7'b1000000, 7, 1'b0);
            end
            begin
                for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
                while (out_valid && run < 100) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        n_cmp++;
        if (run !== 30) begin
            n_err++;
            $display("FAIL back_to_back_run: got %0d valid cycles, required 30", run);
        end
        wait_drain();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL back_to_back_drain: got left=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_sink_stall();
        push_frame(CW_G);
        drive(7'b0000001, 7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_bit, out_last, in_ready} !== 4'b1000) begin
                n_err++;
                $display("FAIL stall_hold: got v/b/l/in_ready %b%b%b%b, required 1000",
                         out_valid, out_bit, out_last, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL stall_drain: got left=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_clear();
        // first three bits of 0101xxx reach the sink; the fourth is held pending and discarded
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b000);
        drive(7'b0101000, 4, 1'b0);
        out_ready = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL clear_state: got v/busy/in_ready %b%b%b, required 001", out_valid, busy, in_ready);
        end
        push_frame(CW_G);
        drive(7'b0000001, 7, 1'b0);
        wait_drain();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL clear_drain: got left=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        push_frame(CW_X6);
        drive(7'b1000000, 7, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_bit, out_first, out_last, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL async_reset: got v/b/f/l/busy %b%b%b%b%b, required 00000",
                     out_valid, out_bit, out_first, out_last, busy);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_frame(CW_G);
        drive(7'b0000001, 7, 1'b0);
        wait_drain();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL reset_recover_drain: got left=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        bit done;
        done = 0;
        fork
            begin
                for (int f = 0; f < 8; f++) begin
                    logic [6:0] m;
                    m = 7'($urandom_range(0, 127));
                    push_frame(encode(m));
                    drive(m, 7, 1'b0);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL random_drain: got left=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_sink_stall();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
